// File: rtl/i2c_fifo.sv
// Synchronous first-word-fall-through FIFO with registered-state level flags
// and a same-cycle error strobe for overflow/underflow requests.
module i2c_fifo #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              WR_ENA,
   input  logic              RD_ENA,
   input  logic [DWIDTH-1:0] DATA_IN,
   output logic [DWIDTH-1:0] DATA_OUT,
   output logic              FULL,
   output logic              EMPTY,
   output logic [AWIDTH:0]   LEVEL,
   output logic              ERROR
);

   localparam int              DEPTH_N  = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] DEPTH    = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0] CNT_ZERO = {(AWIDTH+1){1'b0}};
   localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH-1:0] PTR_ZERO = {AWIDTH{1'b0}};
   localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

   logic [DWIDTH-1:0] mem_q [DEPTH_N];
   logic [AWIDTH-1:0] wp_q, wp_d;
   logic [AWIDTH-1:0] rp_q, rp_d;
   logic [AWIDTH:0]   cnt_q, cnt_d;
   logic              full_s, empty_s;
   logic              wr_acc_s, rd_acc_s;

   // Acceptance decode and next-state pointer/count arithmetic
   always_comb begin
      full_s   = (cnt_q == DEPTH);
      empty_s  = (cnt_q == CNT_ZERO);
      // A push into a full queue is legal when a pop frees the head slot
      wr_acc_s = WR_ENA & (~full_s | RD_ENA);
      rd_acc_s = RD_ENA & ~empty_s;
      wp_d     = wp_q;
      rp_d     = rp_q;
      cnt_d    = cnt_q;
      if (wr_acc_s) begin
         wp_d = wp_q + PTR_ONE;
      end else begin
         wp_d = wp_q;
      end
      if (rd_acc_s) begin
         rp_d = rp_q + PTR_ONE;
      end else begin
         rp_d = rp_q;
      end
      case ({wr_acc_s, rd_acc_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers with synchronous active-low reset
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wp_q  <= PTR_ZERO;
         rp_q  <= PTR_ZERO;
         cnt_q <= CNT_ZERO;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents survive reset, a write during reset is dropped
   always_ff @(posedge PCLK) begin
      if (PRESETn && wr_acc_s) begin
         mem_q[wp_q] <= DATA_IN;
      end
   end

   assign DATA_OUT = mem_q[rp_q];
   assign FULL     = full_s;
   assign EMPTY    = empty_s;
   assign LEVEL    = cnt_q;
   assign ERROR    = (PRESETn & WR_ENA & full_s & ~RD_ENA) | (RD_ENA & empty_s);

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed bench for i2c_fifo: expected words queue up as writes are issued,
// a monitor pops and compares them whenever the DUT accepts a read.
module tb_i2c_fifo;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        WR_ENA = 1'b0;
   logic        RD_ENA = 1'b0;
   logic [31:0] DATA_IN = 32'h0;
   logic [31:0] DATA_OUT;
   logic        FULL, EMPTY, ERROR;
   logic [5:0]  LEVEL;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   i2c_fifo #(.DWIDTH(32), .AWIDTH(5)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .WR_ENA(WR_ENA), .RD_ENA(RD_ENA),
      .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .FULL(FULL), .EMPTY(EMPTY),
      .LEVEL(LEVEL), .ERROR(ERROR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every accepted read must present the oldest expected word
   always @(negedge PCLK) begin
      if (PRESETn && RD_ENA && !EMPTY) begin
         if (exp_q.size() == 0) begin
            chk("read_with_no_expected_word", DATA_OUT, 32'hFFFF_FFFF);
         end else begin
            chk("read_data", DATA_OUT, exp_q.pop_front());
         end
      end
   end

   // One clock of stimulus; exp_acc says whether the write should be stored
   task automatic drive(input logic wr, input logic rd, input logic [31:0] d,
                        input logic exp_acc, input logic exp_err);
      WR_ENA = wr;
      RD_ENA = rd;
      DATA_IN = d;
      if (wr && exp_acc) exp_q.push_back(d);
      #2;
      chk("error_flag", {31'b0, ERROR}, {31'b0, exp_err});
      @(posedge PCLK);
      #1;
      WR_ENA = 1'b0;
      RD_ENA = 1'b0;
   endtask

   task automatic chk_state(input string name, input int lvl);
      chk({name, "_level"}, {26'b0, LEVEL}, 32'(lvl));
      chk({name, "_empty"}, {31'b0, EMPTY}, {31'b0, (lvl == 0)});
      chk({name, "_full"},  {31'b0, FULL},  {31'b0, (lvl == 32)});
   endtask

   initial begin
      // Reset held for two edges
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      chk_state("reset", 0);
      chk("reset_error", {31'b0, ERROR}, 32'h0);

      // Single write, FWFT data, single read
      drive(1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0);
      chk_state("one_write", 1);
      chk("fwft_head", DATA_OUT, 32'hA5A5_0001);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk_state("one_read", 0);

      // Fill, overflow attempt, drain
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      chk_state("filled", 32);
      drive(1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 1'b1);
      chk_state("overflow", 32);
      for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk_state("drained", 0);

      // Two 20-word bursts cross the pointer wrap
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 32'h1000 + 32'(r * 20 + i), 1'b1, 1'b0);
         chk_state("wrap_fill", 20);
         for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
         chk_state("wrap_drain", 0);
      end

      // Simultaneous push/pop while full
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 32'h100 + 32'(i), 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
      chk_state("full_rw", 32);
      chk("full_rw_head", DATA_OUT, 32'h101);
      for (int i = 0; i < 31; i++) drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk("full_rw_last", DATA_OUT, 32'h55);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk_state("full_rw_drained", 0);

      // Simultaneous push/pop while empty: write taken, read is underflow
      drive(1'b1, 1'b1, 32'h77, 1'b1, 1'b1);
      chk_state("empty_rw", 1);
      chk("empty_rw_head", DATA_OUT, 32'h77);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk_state("empty_rw_drained", 0);

      // Reset mid-stream beats a concurrent write
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 32'h200 + 32'(i), 1'b1, 1'b0);
      chk_state("pre_reset", 10);
      PRESETn = 1'b0;
      WR_ENA = 1'b1;
      DATA_IN = 32'h0000_BEEF;
      #2;
      chk("reset_wr_error", {31'b0, ERROR}, 32'h0);
      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      WR_ENA = 1'b0;
      exp_q.delete();
      chk_state("post_reset", 0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk_state("post_reset_underflow", 0);

      repeat (2) @(posedge PCLK);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_fifo.md
I2C_FIFO -- requirements
Module: i2c_fifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 5, pointer width; depth = 2**AWIDTH entries (32).
REQ-003 The block SHALL have port PCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port PRESETn  input  1  reset; synchronous and active-low.
REQ-005 The block SHALL have port WR_ENA  input  1  push request, one word per cycle while high.
REQ-006 The block SHALL have port RD_ENA  input  1  pop request, one word per cycle while high.
REQ-007 The block SHALL have port DATA_IN  input  DWIDTH  word pushed on an accepted write.
REQ-008 The block SHALL have port DATA_OUT  output  DWIDTH  head-of-queue word, first-word-fall-through.
REQ-009 The block SHALL have port FULL  output  1  high when LEVEL == 2**AWIDTH.
REQ-010 The block SHALL have port EMPTY  output  1  high when LEVEL == 0.
REQ-011 The block SHALL have port LEVEL  output  AWIDTH+1  number of stored words, 0..2**AWIDTH.
REQ-012 The block SHALL have port ERROR  output  1  same-cycle flag for an illegal request (overflow or underflow).

Function
REQ-013 Storage SHALL be a DWIDTH x 2**AWIDTH register array plus AWIDTH-bit write pointer WP and read pointer RP, and an AWIDTH+1-bit count.
REQ-014 Write accepted SHALL be defined as WR_ENA & (!FULL | RD_ENA); on acceptance mem[WP] <= DATA_IN and WP <= WP+1 at the same edge.
REQ-015 Read accepted SHALL be defined as RD_ENA & !EMPTY; on acceptance RP <= RP+1 at the edge.
REQ-016 DATA_OUT SHALL equal mem[RP] combinationally, so the head word is valid in the same cycle RD_ENA is sampled; value is don't-care when EMPTY.
REQ-017 Pointers SHALL wrap modulo 2**AWIDTH (31+1 -> 0) with no other side effect.
REQ-018 LEVEL SHALL be +1 on write-only acceptance, -1 on read-only acceptance, and unchanged on both or neither.
REQ-019 FULL, EMPTY and LEVEL SHALL be registered-state derived, updating one edge after the accepted operation (write latency to EMPTY deassertion = 1 cycle).
REQ-020 Simultaneous WR_ENA and RD_ENA while FULL SHALL both be accepted: head popped, new word stored in the freed slot, LEVEL stays 2**AWIDTH, ERROR low.
REQ-021 Simultaneous WR_ENA and RD_ENA while EMPTY SHALL accept the write only; the read is an underflow, LEVEL becomes 1, ERROR high that cycle.
REQ-022 ERROR SHALL be combinational: (WR_ENA & FULL & !RD_ENA) | (RD_ENA & EMPTY); a rejected write SHALL NOT modify memory or WP, and a rejected read SHALL NOT modify RP.
REQ-023 Memory contents SHALL not be cleared by reset; only pointers and count are reset.

Reset
REQ-024 When PRESETn is low at a rising edge, WP, RP and count SHALL become 0, giving EMPTY=1, FULL=0, LEVEL=0 from the next cycle.
REQ-025 Reset SHALL take priority over any same-cycle WR_ENA/RD_ENA; the request SHALL be discarded, including in mid-stream.
REQ-026 ERROR SHALL be low during and after reset unless RD_ENA is high while EMPTY.

Verification
REQ-027 Reset, then write 0xA5A5_0001 -> next cycle EMPTY=0, LEVEL=1, DATA_OUT=0xA5A5_0001; pulse RD_ENA -> next cycle EMPTY=1, LEVEL=0.
REQ-028 Write 32 words 0..31 -> FULL=1, LEVEL=32; 33rd write of 0xDEAD alone -> ERROR=1 that cycle, LEVEL stays 32; read all 32 -> values 0..31 in order, no 0xDEAD.
REQ-029 Write 20, read 20, write 20, read 20 -> order preserved across pointer wrap, LEVEL returns to 0, ERROR never high.
REQ-030 With FULL, WR_ENA=RD_ENA=1 with DATA_IN=0x55 -> ERROR=0, LEVEL=32, DATA_OUT advances to second word; after 31 more reads DATA_OUT=0x55.
REQ-031 From EMPTY, WR_ENA=RD_ENA=1 with DATA_IN=0x77 -> ERROR=1 that cycle, next cycle LEVEL=1, DATA_OUT=0x77.
REQ-032 With LEVEL=10, assert PRESETn=0 together with WR_ENA=1 -> next cycle LEVEL=0, EMPTY=1, FULL=0; a subsequent RD_ENA gives ERROR=1.
